// File: rtl/bcd_timer_ctrl.sv
// DIGITS-wide BCD timer: count-down/count-up, pause/resume, terminal DONE state with a
// flashing LED alarm, and an active-low 7-segment decode of the count register.
module bcd_timer_ctrl #(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 50000000,
    parameter int FLASH_DIV = 12500000,
    parameter int LED_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_stop,
    input  logic                  set,
    input  logic                  clear,
    input  logic                  count_up,
    input  logic [4*DIGITS-1:0]   sw_bcd,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  running,
    output logic                  expired,
    output logic [LED_W-1:0]      ledr
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int FW = $clog2(FLASH_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;

    function automatic logic [BW-1:0] clamp_bcd(input logic [BW-1:0] v);
        clamp_bcd = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) clamp_bcd[4*i +: 4] = 4'd9;
    endfunction

    // One BCD step; the ripple stops at the first digit that does not wrap.
    function automatic logic [BW-1:0] step_bcd(input logic [BW-1:0] v, input logic up);
        logic       carry;
        logic [3:0] d;
        step_bcd = v;
        carry    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (d == 4'd9) step_bcd[4*i +: 4] = 4'd0;
                    else begin step_bcd[4*i +: 4] = d + 4'd1; carry = 1'b0; end
                end else begin
                    if (d == 4'd0) step_bcd[4*i +: 4] = 4'd9;
                    else begin step_bcd[4*i +: 4] = d - 4'd1; carry = 1'b0; end
                end
            end
        end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   load_q, load_d;
    logic            up_q, up_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
    logic            flash_q, flash_d;

    logic [BW-1:0]   sw_clamped, bcd_next, start_val, target;
    logic            tick;

    // load_q holds the clamped load; its role (start or target) follows the mode.
    assign sw_clamped = clamp_bcd(sw_bcd);
    assign bcd_next   = step_bcd(bcd_q, up_q);
    assign start_val  = up_q ? '0 : load_q;
    assign target     = up_q ? load_q : '0;
    assign tick       = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    // NOTE: every _d is defaulted to its _q first, so no path through the
    // case below can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        load_d      = load_q;
        up_d        = up_q;
        presc_d     = presc_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;

        if (clear) begin
            bcd_d   = start_val;
            presc_d = '0;
            state_d = ST_IDLE;
        end else if (set) begin
            load_d  = sw_clamped;
            up_d    = count_up;
            bcd_d   = count_up ? '0 : sw_clamped;
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_stop && (bcd_q != target)) state_d = ST_RUN;
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) bcd_d = bcd_next;
                    if (tick && (bcd_next == target)) begin
                        state_d     = ST_DONE;
                        flash_cnt_d = '0;
                        flash_d     = 1'b1;
                    end else if (start_stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (start_stop) state_d = ST_RUN;
                ST_DONE: begin
                    if (flash_cnt_q == FLASH_MAX) begin
                        flash_cnt_d = '0;
                        flash_d     = ~flash_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bcd_q       <= '0;
            load_q      <= '0;
            up_q        <= 1'b0;
            presc_q     <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            load_q      <= load_d;
            up_q        <= up_d;
            presc_q     <= presc_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
        end
    end

    always_comb begin
        bcd     = bcd_q;
        running = (state_q == ST_RUN);
        expired = (state_q == ST_DONE);
        case (state_q)
            ST_RUN:  ledr = LED_W'(1);
            ST_DONE: ledr = {LED_W{flash_q}};
            default: ledr = '0;
        endcase
        hex = '0;
        for (int i = 0; i < DIGITS; i++) hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: integer-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_bcd_timer_ctrl;

    localparam int DIGITS    = 2;
    localparam int TICK_DIV  = 4;
    localparam int FLASH_DIV = 3;
    localparam int LED_W     = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_stop = 1'b0, set = 1'b0, clear = 1'b0, count_up = 1'b0;
    logic [7:0]  sw_bcd = 8'h00;
    logic [7:0]  bcd;
    logic [13:0] hex;
    logic        running, expired;
    logic [9:0]  ledr;

    int n_checks = 0;
    int n_errors = 0;

    bcd_timer_ctrl #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .FLASH_DIV(FLASH_DIV), .LED_W(LED_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .set(set), .clear(clear),
        .count_up(count_up), .sw_bcd(sw_bcd), .bcd(bcd), .hex(hex),
        .running(running), .expired(expired), .ledr(ledr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (decimal integers) ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} m_state_e;
    m_state_e m_state    = M_IDLE;
    int       m_cnt      = 0;
    int       m_load     = 0;
    bit       m_up       = 1'b0;
    int       m_phase    = 0;
    int       m_done_cyc = 0;

    function automatic int clamp_dec(input logic [7:0] v);
        int hi, lo;
        hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_state = M_IDLE; m_cnt = 0; m_load = 0; m_up = 1'b0;
                m_phase = 0; m_done_cyc = 0;
            end else if (clear) begin
                m_cnt = m_up ? 0 : m_load; m_phase = 0; m_state = M_IDLE;
            end else if (set) begin
                m_load = clamp_dec(sw_bcd); m_up = count_up;
                m_cnt = m_up ? 0 : m_load; m_phase = 0; m_state = M_IDLE;
            end else begin
                case (m_state)
                    M_IDLE:  if (start_stop && m_cnt != (m_up ? m_load : 0)) m_state = M_RUN;
                    M_RUN: begin
                        m_phase++;
                        if (m_phase == TICK_DIV) begin
                            m_phase = 0;
                            m_cnt += m_up ? 1 : -1;
                        end
                        if (m_cnt == (m_up ? m_load : 0)) begin
                            m_state = M_DONE; m_done_cyc = 0;
                        end else if (start_stop) begin
                            m_state = M_PAUSE;
                        end
                    end
                    M_PAUSE: if (start_stop) m_state = M_RUN;
                    M_DONE:  m_done_cyc++;
                    default: m_state = M_IDLE;
                endcase
            end
        end
    end

    // Single compare process: every falling edge, all outputs against the model.
    initial begin
        logic [9:0] exp_led;
        forever begin
            @(negedge clk);
            if (m_state == M_DONE)
                exp_led = ((m_done_cyc / FLASH_DIV) % 2 == 0) ? 10'h3FF : 10'h000;
            else
                exp_led = (m_state == M_RUN) ? 10'h001 : 10'h000;
            check("model_bcd", 32'(bcd), 32'({4'(m_cnt / 10), 4'(m_cnt % 10)}));
            check("model_hex", 32'(hex), 32'({seg(m_cnt / 10), seg(m_cnt % 10)}));
            check("model_running", 32'(running), 32'(m_state == M_RUN));
            check("model_expired", 32'(expired), 32'(m_state == M_DONE));
            check("model_ledr", 32'(ledr), 32'(exp_led));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input logic p_ss, input logic p_set, input logic p_clr);
        start_stop = p_ss; set = p_set; clear = p_clr;
        @(negedge clk);
        start_stop = 1'b0; set = 1'b0; clear = 1'b0;
    endtask

    task automatic load(input logic [7:0] v, input logic up);
        sw_bcd = v; count_up = up;
        pulse(1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_expired(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (expired) break;
            @(negedge clk);
        end
        check(name, 32'(expired), 32'd1);
    endtask

    task automatic wait_bcd(input logic [7:0] v, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (bcd == v) break;
            @(negedge clk);
        end
        check(name, 32'(bcd), 32'(v));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_bcd", 32'(bcd), 32'h00);
        check("rst_hex", 32'(hex), 32'h2040);
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_expired", 32'(expired), 32'd0);

        // Start with count == target is ignored.
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_start_ignored", 32'(running), 32'd0);

        // Count down from 12, borrow at 10 -> 09.
        load(8'h12, 1'b0);
        check("load12_bcd", 32'(bcd), 32'h12);
        check("load12_hex", 32'(hex), 32'({7'h79, 7'h24}));
        pulse(1'b1, 1'b0, 1'b0);
        check("down_running", 32'(running), 32'd1);
        check("down_ledr_run", 32'(ledr), 32'h001);
        repeat (3) @(negedge clk);
        check("down_pre_tick", 32'(bcd), 32'h12);
        @(negedge clk);
        check("down_tick1", 32'(bcd), 32'h11);
        repeat (4) @(negedge clk);
        check("down_tick2", 32'(bcd), 32'h10);
        repeat (4) @(negedge clk);
        check("down_borrow", 32'(bcd), 32'h09);
        wait_expired(45, "down_done_reached");
        check("down_done_bcd", 32'(bcd), 32'h00);
        check("down_done_running", 32'(running), 32'd0);
        check("flash_c0", 32'(ledr), 32'h3FF);
        repeat (2) @(negedge clk);
        check("flash_c2", 32'(ledr), 32'h3FF);
        @(negedge clk);
        check("flash_c3", 32'(ledr), 32'h000);
        repeat (2) @(negedge clk);
        check("flash_c5", 32'(ledr), 32'h000);
        @(negedge clk);
        check("flash_c6", 32'(ledr), 32'h3FF);
        pulse(1'b1, 1'b0, 1'b0);
        check("done_ignores_start", 32'(expired), 32'd1);

        // Count up to clamped 19, carry at 09 -> 10.
        load(8'h1F, 1'b1);
        check("up_load_bcd", 32'(bcd), 32'h00);
        check("up_load_expired", 32'(expired), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_bcd(8'h08, 45, "up_reach_08");
        repeat (4) @(negedge clk);
        check("up_09", 32'(bcd), 32'h09);
        repeat (4) @(negedge clk);
        check("up_carry_10", 32'(bcd), 32'h10);
        wait_expired(50, "up_done_reached");
        check("up_done_bcd", 32'(bcd), 32'h19);

        // Pause holds count and prescaler phase.
        load(8'h05, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        check("pause_bcd", 32'(bcd), 32'h04);
        check("pause_running", 32'(running), 32'd0);
        check("pause_ledr", 32'(ledr), 32'h000);
        repeat (20) @(negedge clk);
        check("pause_hold", 32'(bcd), 32'h04);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_running", 32'(running), 32'd1);
        @(negedge clk);
        check("resume_1cyc", 32'(bcd), 32'h04);
        @(negedge clk);
        check("resume_tick", 32'(bcd), 32'h03);

        // clear > set > start_stop in one cycle.
        sw_bcd = 8'h77; count_up = 1'b1;
        pulse(1'b1, 1'b1, 1'b1);
        check("prio_bcd", 32'(bcd), 32'h05);
        check("prio_running", 32'(running), 32'd0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("prio_mode_kept", 32'(bcd), 32'h04);

        // Asynchronous reset mid-run, between clock edges.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_bcd", 32'(bcd), 32'h00);
        check("arst_ledr", 32'(ledr), 32'h000);
        check("arst_running", 32'(running), 32'd0);
        check("arst_expired", 32'(expired), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        check("arst_start_ignored", 32'(running), 32'd0);

        // Nibble clamp in down mode: A3 -> 93.
        load(8'hA3, 1'b0);
        check("clamp_bcd", 32'(bcd), 32'h93);
        check("clamp_hex", 32'(hex), 32'({7'h10, 7'h30}));
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
